// File: rtl/bfm_apbmem_responder.sv
// APB3 completer backed by a zero-initialised word memory, with programmable wait states,
// out-of-window error responses, a sticky protocol-violation flag and transfer counters.
module bfm_apbmem_responder #(
   parameter int AWIDTH = 8,
   parameter int WAITS  = 0,
   parameter int TPD    = 1
) (
   input  logic        PCLK,
   input  logic        PRESETN,
   input  logic        PSEL,
   input  logic [31:0] PADDR,
   input  logic        PENABLE,
   input  logic        PWRITE,
   input  logic [31:0] PWDATA,
   output logic [31:0] PRDATA,
   output logic        PREADY,
   output logic        PSLVERR,
   output logic        PROTERR,
   output logic [15:0] WRCOUNT,
   output logic [15:0] RDCOUNT
);

   localparam int DEPTH = 1 << AWIDTH;
   // TPD only describes the simulation-side output delay; the logic itself updates at the edge.
   localparam bit PARAMS_OK = (AWIDTH >= 2) && (AWIDTH <= 16) && (WAITS >= 0) &&
                              (WAITS <= 15) && (TPD >= 0);

   if (!PARAMS_OK) begin : g_param_check
      $error("bfm_apbmem_responder: parameter out of range");
   end

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t            state_reg, state_next;
   logic [3:0]        cnt_reg, cnt_next;
   logic [31:0]       paddr_reg, paddr_next;
   logic              pwrite_reg, pwrite_next;
   logic [31:0]       pwdata_reg, pwdata_next;
   logic              inwin_reg, inwin_next;
   logic              proterr_reg, proterr_next;
   logic [15:0]       wr_count_reg, wr_count_next;
   logic [15:0]       rd_count_reg, rd_count_next;
   logic              mem_we;
   logic              addr_inwin;
   logic [AWIDTH-1:0] word_idx;

   logic [31:0] mem_reg [DEPTH] = '{default: 32'h0};

   assign addr_inwin = ((PADDR >> (AWIDTH + 2)) == 32'd0);
   assign word_idx   = paddr_reg[AWIDTH+1:2];

   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         state_reg    <= IDLE;
         cnt_reg      <= 4'd0;
         paddr_reg    <= 32'd0;
         pwrite_reg   <= 1'b0;
         pwdata_reg   <= 32'd0;
         inwin_reg    <= 1'b0;
         proterr_reg  <= 1'b0;
         wr_count_reg <= 16'd0;
         rd_count_reg <= 16'd0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         paddr_reg    <= paddr_next;
         pwrite_reg   <= pwrite_next;
         pwdata_reg   <= pwdata_next;
         inwin_reg    <= inwin_next;
         proterr_reg  <= proterr_next;
         wr_count_reg <= wr_count_next;
         rd_count_reg <= rd_count_next;
      end
   end

   // Memory survives reset; mem_we can only fire from ACCESS, so a reset discards pending writes.
   always_ff @(posedge PCLK) begin
      if (mem_we) begin
         mem_reg[word_idx] <= pwdata_reg;
      end
   end

   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      paddr_next    = paddr_reg;
      pwrite_next   = pwrite_reg;
      pwdata_next   = pwdata_reg;
      inwin_next    = inwin_reg;
      proterr_next  = proterr_reg;
      wr_count_next = wr_count_reg;
      rd_count_next = rd_count_reg;
      mem_we        = 1'b0;
      case (state_reg)
         IDLE: begin
            if (PSEL && !PENABLE) begin
               paddr_next  = PADDR;
               pwrite_next = PWRITE;
               pwdata_next = PWDATA;
               inwin_next  = addr_inwin;
               cnt_next    = 4'(WAITS);
               state_next  = ACCESS;
            end else if (PSEL && PENABLE) begin
               proterr_next = 1'b1;
            end
         end
         ACCESS: begin
            // Master changed the transfer under us: flag it but keep using the latched values.
            if ((PADDR != paddr_reg) || (PWRITE != pwrite_reg) ||
                (pwrite_reg && (PWDATA != pwdata_reg))) begin
               proterr_next = 1'b1;
            end
            if (!(PSEL && PENABLE)) begin
               proterr_next = 1'b1;
               state_next   = IDLE;
            end else if (cnt_reg != 4'd0) begin
               cnt_next = cnt_reg - 4'd1;
            end else begin
               state_next = IDLE;
               if (inwin_reg) begin
                  if (pwrite_reg) begin
                     mem_we        = 1'b1;
                     wr_count_next = wr_count_reg + 16'd1;
                  end else begin
                     rd_count_next = rd_count_reg + 16'd1;
                  end
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign PREADY  = (state_reg == ACCESS) && (cnt_reg == 4'd0);
   assign PSLVERR = PREADY && !inwin_reg;
   assign PRDATA  = ((state_reg == ACCESS) && !pwrite_reg && inwin_reg) ? mem_reg[word_idx] : 32'h0;
   assign PROTERR = proterr_reg;
   assign WRCOUNT = wr_count_reg;
   assign RDCOUNT = rd_count_reg;

endmodule

// File: tb/tb_bfm_apbmem_responder.sv
// Bench for bfm_apbmem_responder: three completers (WAITS 0, 3, 2) share one APB bus, each on
// its own PSEL line; table-driven transfers plus hand-written abandon/mismatch/reset/wrap sequences.
module tb_bfm_apbmem_responder;

   localparam int NDUT = 3;
   localparam int TO   = 40;

   function automatic int waits_of(int k);
      return (k == 0) ? 0 : ((k == 1) ? 3 : 2);
   endfunction

   logic            pclk    = 1'b0;
   logic            presetn = 1'b0;
   logic [NDUT-1:0] psel    = '0;
   logic [31:0]     paddr   = 32'h0;
   logic            penable = 1'b0;
   logic            pwrite  = 1'b0;
   logic [31:0]     pwdata  = 32'h0;
   logic [31:0]     prdata  [NDUT];
   logic            pready  [NDUT];
   logic            pslverr [NDUT];
   logic            proterr [NDUT];
   logic [15:0]     wrcount [NDUT];
   logic [15:0]     rdcount [NDUT];

   int n_vec = 0;
   int n_err = 0;
   logic [15:0] exp_wr [NDUT];
   logic [15:0] exp_rd [NDUT];

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;
   exp_t sb_q[$];

   typedef struct {
      int          tgt;
      int          gap;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
   } vec_t;
   vec_t vt [17];

   always #5 pclk = ~pclk;

   for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
      bfm_apbmem_responder #(
         .AWIDTH(8),
         .WAITS (waits_of(gi)),
         .TPD   (1)
      ) u_dut (
         .PCLK   (pclk),
         .PRESETN(presetn),
         .PSEL   (psel[gi]),
         .PADDR  (paddr),
         .PENABLE(penable),
         .PWRITE (pwrite),
         .PWDATA (pwdata),
         .PRDATA (prdata[gi]),
         .PREADY (pready[gi]),
         .PSLVERR(pslverr[gi]),
         .PROTERR(proterr[gi]),
         .WRCOUNT(wrcount[gi]),
         .RDCOUNT(rdcount[gi])
      );
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      for (int k = 0; k < NDUT; k++) begin
         check($sformatf("%s_prdata[%0d]", tag, k), prdata[k], 32'h0);
         check($sformatf("%s_pready[%0d]", tag, k), 32'(pready[k]), 32'h0);
         check($sformatf("%s_pslverr[%0d]", tag, k), 32'(pslverr[k]), 32'h0);
         check($sformatf("%s_proterr[%0d]", tag, k), 32'(proterr[k]), 32'h0);
         check($sformatf("%s_wrcount[%0d]", tag, k), 32'(wrcount[k]), 32'h0);
         check($sformatf("%s_rdcount[%0d]", tag, k), 32'(rdcount[k]), 32'h0);
      end
   endtask

   task automatic check_counts(input int tgt, input string tag);
      check($sformatf("%s_wrcount[%0d]", tag, tgt), 32'(wrcount[tgt]), 32'(exp_wr[tgt]));
      check($sformatf("%s_rdcount[%0d]", tag, tgt), 32'(rdcount[tgt]), 32'(exp_rd[tgt]));
   endtask

   // One full APB transfer; returns 1 ns after the completing edge so a following call is back-to-back.
   task automatic apb_xfer(input int tgt, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err);
      int   cyc;
      exp_t e;
      @(negedge pclk);
      check($sformatf("pready_idle[%0d]", tgt), 32'(pready[tgt]), 32'h0);
      e.rdata = exp_rdata;
      e.err   = exp_err;
      sb_q.push_back(e);
      psel      = '0;
      psel[tgt] = 1'b1;
      penable   = 1'b0;
      paddr     = addr;
      pwrite    = wr;
      pwdata    = wdata;
      @(negedge pclk);
      penable = 1'b1;
      cyc     = 1;
      while (!pready[tgt] && cyc < TO) begin
         @(negedge pclk);
         cyc++;
      end
      e = sb_q.pop_front();
      if (!pready[tgt]) begin
         n_vec++;
         n_err++;
         $display("FAIL timeout[%0d]: PREADY still 0 after %0d cycles, expected after %0d",
                  tgt, cyc, waits_of(tgt) + 1);
      end else begin
         check($sformatf("latency[%0d]", tgt), 32'(cyc), 32'(waits_of(tgt) + 1));
         check($sformatf("prdata[%0d]@%08h", tgt, addr), prdata[tgt], e.rdata);
         check($sformatf("pslverr[%0d]@%08h", tgt, addr), 32'(pslverr[tgt]), 32'(e.err));
      end
      $display("xfer dut%0d %s addr=%08h wdata=%08h rdata=%08h err=%0b cycles=%0d",
               tgt, wr ? "WR" : "RD", addr, wdata, prdata[tgt], pslverr[tgt], cyc);
      @(posedge pclk);
      #1;
      psel    = '0;
      penable = 1'b0;
      if (!exp_err) begin
         if (wr) exp_wr[tgt] = exp_wr[tgt] + 16'd1;
         else    exp_rd[tgt] = exp_rd[tgt] + 16'd1;
      end
      check_counts(tgt, "cnt");
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < NDUT; k++) begin
         exp_wr[k] = 16'd0;
         exp_rd[k] = 16'd0;
      end
      //         tgt gap wr    addr           wdata          rdata          err
      vt[0]  = '{0, 1, 1'b1, 32'h0000_0010, 32'hA5A5_1234, 32'h0,         1'b0};
      vt[1]  = '{0, 0, 1'b0, 32'h0000_0010, 32'h0,         32'hA5A5_1234, 1'b0};
      vt[2]  = '{0, 0, 1'b1, 32'h0000_0000, 32'h1111_2222, 32'h0,         1'b0};
      vt[3]  = '{0, 1, 1'b1, 32'h0000_03FF, 32'hCAFE_F00D, 32'h0,         1'b0};
      vt[4]  = '{0, 0, 1'b1, 32'h0000_0400, 32'hDEAD_BEEF, 32'h0,         1'b1};
      vt[5]  = '{0, 0, 1'b0, 32'h0000_0400, 32'h0,         32'h0,         1'b1};
      vt[6]  = '{0, 0, 1'b0, 32'h0000_0000, 32'h0,         32'h1111_2222, 1'b0};
      vt[7]  = '{0, 2, 1'b0, 32'h0000_03FC, 32'h0,         32'hCAFE_F00D, 1'b0};
      vt[8]  = '{0, 0, 1'b0, 32'h8000_0000, 32'h0,         32'h0,         1'b1};
      vt[9]  = '{1, 2, 1'b1, 32'h0000_0020, 32'h1000_0001, 32'h0,         1'b0};
      vt[10] = '{1, 0, 1'b1, 32'h0000_0024, 32'h2000_0002, 32'h0,         1'b0};
      vt[11] = '{1, 0, 1'b1, 32'h0000_0028, 32'h3000_0003, 32'h0,         1'b0};
      vt[12] = '{1, 0, 1'b1, 32'h0000_002C, 32'h4000_0004, 32'h0,         1'b0};
      vt[13] = '{1, 0, 1'b0, 32'h0000_0024, 32'h0,         32'h2000_0002, 1'b0};
      vt[14] = '{1, 0, 1'b0, 32'h0000_0020, 32'h0,         32'h1000_0001, 1'b0};
      vt[15] = '{1, 0, 1'b0, 32'h0000_002C, 32'h0,         32'h4000_0004, 1'b0};
      vt[16] = '{1, 0, 1'b0, 32'h0000_0028, 32'h0,         32'h3000_0003, 1'b0};

      repeat (2) @(negedge pclk);
      check_all_zero("reset");
      presetn = 1'b1;

      foreach (vt[i]) begin
         repeat (vt[i].gap) @(negedge pclk);
         apb_xfer(vt[i].tgt, vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].rdata, vt[i].err);
      end
      for (int k = 0; k < NDUT; k++)
         check($sformatf("proterr_clean[%0d]", k), 32'(proterr[k]), 32'h0);

      // Abandoned write on the WAITS=2 completer while its wait counter is still running.
      @(negedge pclk);
      psel = 3'b100; penable = 1'b0; paddr = 32'h40; pwrite = 1'b1; pwdata = 32'h5555_AAAA;
      @(negedge pclk);
      penable = 1'b1;
      @(negedge pclk);
      check("abandon_pready", 32'(pready[2]), 32'h0);
      psel = '0; penable = 1'b0;
      @(posedge pclk);
      #1;
      check("abandon_proterr", 32'(proterr[2]), 32'h1);
      check("abandon_pready_after", 32'(pready[2]), 32'h0);
      check_counts(2, "abandon");
      apb_xfer(2, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0);
      check("abandon_proterr_sticky", 32'(proterr[2]), 32'h1);

      // PADDR changes during the access phase; the transfer still uses the latched address.
      check("mismatch_proterr_before", 32'(proterr[0]), 32'h0);
      @(negedge pclk);
      psel = 3'b001; penable = 1'b0; paddr = 32'h50; pwrite = 1'b1; pwdata = 32'h7777_8888;
      @(negedge pclk);
      penable = 1'b1;
      paddr   = 32'h54;
      check("mismatch_pready", 32'(pready[0]), 32'h1);
      @(posedge pclk);
      #1;
      psel = '0; penable = 1'b0;
      exp_wr[0] = exp_wr[0] + 16'd1;
      check("mismatch_proterr", 32'(proterr[0]), 32'h1);
      check_counts(0, "mismatch");
      apb_xfer(0, 1'b0, 32'h50, 32'h0, 32'h7777_8888, 1'b0);
      apb_xfer(0, 1'b0, 32'h54, 32'h0, 32'h0, 1'b0);
      check("mismatch_proterr_sticky", 32'(proterr[0]), 32'h1);

      // Reset asserted during the access phase of a write on the WAITS=3 completer.
      @(negedge pclk);
      psel = 3'b010; penable = 1'b0; paddr = 32'h20; pwrite = 1'b1; pwdata = 32'hFFFF_0000;
      @(negedge pclk);
      penable = 1'b1;
      @(negedge pclk);
      presetn = 1'b0;
      #1;
      check_all_zero("midreset");
      for (int k = 0; k < NDUT; k++) begin
         exp_wr[k] = 16'd0;
         exp_rd[k] = 16'd0;
      end
      @(negedge pclk);
      psel = '0; penable = 1'b0;
      @(negedge pclk);
      presetn = 1'b1;
      apb_xfer(1, 1'b0, 32'h20, 32'h0, 32'h1000_0001, 1'b0);
      apb_xfer(1, 1'b1, 32'h20, 32'hFFFF_0000, 32'h0, 1'b0);
      apb_xfer(1, 1'b0, 32'h20, 32'h0, 32'hFFFF_0000, 1'b0);

      // Write counter wrap.
      @(negedge pclk);
      force g_dut[0].u_dut.wr_count_reg = 16'hFFFF;
      #1;
      release g_dut[0].u_dut.wr_count_reg;
      exp_wr[0] = 16'hFFFF;
      check("wrap_preload", 32'(wrcount[0]), 32'h0000_FFFF);
      apb_xfer(0, 1'b1, 32'h08, 32'h0123_4567, 32'h0, 1'b0);
      check("wrap_result", 32'(wrcount[0]), 32'h0);

      @(negedge pclk);
      for (int k = 0; k < NDUT; k++)
         check($sformatf("final_pready[%0d]", k), 32'(pready[k]), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
